// File: rtl/fifo_arb_pkg.sv
// Shared types, width helpers and default parameters for the FIFO write-port arbiter.
package fifo_arb_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_MAX_BURST  = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int burst_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward from start, wrapping.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    start,
    output logic               found,
    output logic [ID_W-1:0]    idx
);

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        s = (s >= NUM_REQ) ? (s - NUM_REQ) : s;
        return s[ID_W-1:0];
    endfunction

    // Walk from farthest to nearest so the candidate closest to start overwrites the others.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            found = found | req[wrap_add(start, k)];
            idx   = req[wrap_add(start, k)] ? wrap_add(start, k) : idx;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port; registered write stage,
// overflow-safe issue gating and a sticky check that every issued write is acknowledged.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    input  logic                          fifo_almostfull,
    input  logic                          fifo_wr_ack,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          drop_err,
    output logic [15:0]                   beat_cnt_total
);

    localparam int ID_W = id_width(NUM_REQ);
    localparam int BC_W = burst_width(MAX_BURST);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [BC_W-1:0] BURST_LIM = BC_W'(MAX_BURST);

    arb_state_e            state_q, state_d;
    logic [ID_W-1:0]       owner_q, owner_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [BC_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d;
    logic                  drop_q, drop_d;
    logic                  pend_q, pend_d;
    logic [15:0]           beat_q, beat_d;

    logic                  can_issue;
    logic                  grant;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       pick_start;
    logic                  pick_found;
    logic [ID_W-1:0]       pick_idx;

    function automatic logic [ID_W-1:0] inc_wrap(input logic [ID_W-1:0] v);
        return (v == LAST_ID) ? '0 : (v + ID_W'(1));
    endfunction

    // Ignores concurrent reads, so a write already in flight never over-commits the last slot.
    assign can_issue  = !fifo_full && !(fifo_almostfull && wr_en_q);
    assign pick_start = (state_q == IDLE) ? inc_wrap(rr_ptr_q) : inc_wrap(owner_q);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        grant       = 1'b0;
        grant_idx   = owner_q;
        if (rst || !can_issue) begin
            grant = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant       = 1'b1;
                        grant_idx   = pick_idx;
                        owner_d     = pick_idx;
                        rr_ptr_d    = pick_idx;
                        burst_cnt_d = BC_W'(1);
                        state_d     = BURST;
                    end else begin
                        state_d = IDLE;
                    end
                end
                BURST: begin
                    if (req_valid[owner_q] && (burst_cnt_q < BURST_LIM)) begin
                        grant       = 1'b1;
                        grant_idx   = owner_q;
                        burst_cnt_d = burst_cnt_q + BC_W'(1);
                    end else if (pick_found) begin
                        // Search began at owner+1, so the current owner is considered last.
                        grant       = 1'b1;
                        grant_idx   = pick_idx;
                        owner_d     = pick_idx;
                        rr_ptr_d    = pick_idx;
                        burst_cnt_d = BC_W'(1);
                        state_d     = BURST;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        req_ready  = '0;
        wr_en_d    = grant;
        data_d     = data_q;
        beat_d     = beat_q;
        grant_id_d = grant_id_q;
        pend_d     = wr_en_q;
        drop_d     = drop_q | (pend_q & ~fifo_wr_ack);
        if (grant) begin
            req_ready[grant_idx] = 1'b1;
            data_d               = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            beat_d               = beat_q + 16'd1;
            grant_id_d           = grant_idx;
        end else begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= LAST_ID;
            burst_cnt_q <= '0;
            wr_en_q     <= 1'b0;
            data_q      <= '0;
            grant_id_q  <= '0;
            drop_q      <= 1'b0;
            pend_q      <= 1'b0;
            beat_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            wr_en_q     <= wr_en_d;
            data_q      <= data_d;
            grant_id_q  <= grant_id_d;
            drop_q      <= drop_d;
            pend_q      <= pend_d;
            beat_q      <= beat_d;
        end
    end

    assign fifo_wr_en     = wr_en_q;
    assign fifo_data_in   = data_q;
    assign grant_id       = grant_id_q;
    assign drop_err       = drop_q;
    assign beat_cnt_total = beat_q;

endmodule
